inst_buffer_ss: RTL

- Superscalar successor to the single-entry-per-cycle instruction queue. It sits between fetch (fetch2/branch predictor) and decode.
- Accepts up to IN_WIDTH fetched instructions per cycle into a circular buffer. Presents up to OUT_WIDTH oldest entries per cycle to decode, in program order.
- Supports partial dispatch acceptance, all-or-nothing fetch acceptance, and full flush on branch misprediction.

---
 rtl/inst_buffer_ss_pkg.sv | 39 +++
 rtl/ib_lane_compact.sv | 25 ++
 rtl/inst_buffer_ss.sv | 99 +++++++++
 3 files changed

// File: rtl/inst_buffer_ss_pkg.sv
// Shared fetch/decode types and instruction-buffer parameter defaults.
package inst_buffer_ss_pkg;

    localparam int unsigned XLEN = 32;

    // RISC-V canonical NOP (addi x0, x0, 0).
    localparam logic [XLEN-1:0] NOOP_INST = 32'h0000_0013;

    // Default geometry of the superscalar instruction buffer.
    localparam int unsigned IB_DEPTH     = 16;
    localparam int unsigned IB_IN_WIDTH  = 2;
    localparam int unsigned IB_OUT_WIDTH = 2;

    // Branch-predictor annotations carried alongside each fetched instruction.
    typedef struct packed {
        logic            is_branch;
        logic            pred_taken;
        logic [XLEN-1:0] pred_target;
    } branch_inst_t;

    // One fetched instruction as seen by decode.
    typedef struct packed {
        logic            valid_inst;
        logic [XLEN-1:0] ir;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] npc;
        branch_inst_t    branch_inst;
    } INST_Q;

    // Bubble value used for reset, cleared storage and idle output lanes.
    localparam INST_Q INST_Q_ZERO = '{
        valid_inst:  1'b0,
        ir:          NOOP_INST,
        pc:          '0,
        npc:         '0,
        branch_inst: '0
    };

endpackage

// File: rtl/ib_lane_compact.sv
// Prefix popcount over a lane-valid vector: each lane's compacted slot offset plus the total.
module ib_lane_compact
    import inst_buffer_ss_pkg::*;
#(
    parameter  int unsigned W  = IB_IN_WIDTH,
    localparam int unsigned OW = $clog2(W + 1)
) (
    input  logic [W-1:0]         valid,
    output logic [W-1:0][OW-1:0] offset,
    output logic [OW-1:0]        total
);

    // Exclusive prefix sum: lane i lands after all valid lanes below it.
    always_comb begin
        logic [OW-1:0] run;
        run    = '0;
        offset = '0;
        for (int i = 0; i < int'(W); i++) begin
            offset[i] = run;
            run       = run + OW'(valid[i]);
        end
        total = run;
    end

endmodule

// File: rtl/inst_buffer_ss.sv
// Multi-lane circular instruction buffer between fetch and decode.
module inst_buffer_ss
    import inst_buffer_ss_pkg::*;
#(
    parameter  int unsigned DEPTH     = IB_DEPTH,
    parameter  int unsigned IN_WIDTH  = IB_IN_WIDTH,
    parameter  int unsigned OUT_WIDTH = IB_OUT_WIDTH,
    localparam int unsigned PW        = $clog2(DEPTH),
    localparam int unsigned CW        = $clog2(DEPTH + 1),
    localparam int unsigned DW        = $clog2(OUT_WIDTH + 1)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        flush,
    input  logic [IN_WIDTH-1:0]         in_valid,
    input  INST_Q [IN_WIDTH-1:0]        in_inst,
    output logic                        in_ready,
    output logic [OUT_WIDTH-1:0]        out_valid,
    output INST_Q [OUT_WIDTH-1:0]       out_inst,
    input  logic [DW-1:0]               deq_count,
    output logic [CW-1:0]               count,
    output logic                        full
);

    localparam int unsigned LW = $clog2(IN_WIDTH + 1);

    INST_Q                       storage [DEPTH];
    logic [PW-1:0]               head;
    logic [PW-1:0]               tail;
    logic [IN_WIDTH-1:0][LW-1:0] lane_off;
    logic [LW-1:0]               lane_total;
    logic                        enq_fire;
    logic [CW-1:0]               eff_deq;

    // Modulo-DEPTH pointer advance; k never exceeds DEPTH so one wrap suffices.
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] ptr, input int unsigned k);
        int unsigned sum;
        sum = 32'(ptr) + k;
        return (sum >= DEPTH) ? PW'(sum - DEPTH) : PW'(sum);
    endfunction

    ib_lane_compact #(.W(IN_WIDTH)) u_compact (
        .valid  (in_valid),
        .offset (lane_off),
        .total  (lane_total)
    );

    // Admission looks only at the registered count, keeping deq_count off the fetch path.
    assign in_ready = (CW'(DEPTH) - count) >= CW'(IN_WIDTH);
    assign full     = (count == CW'(DEPTH));
    assign enq_fire = in_ready && (|in_valid) && !flush;

    // Clip the decode request to what is actually presented.
    always_comb begin
        eff_deq = CW'(deq_count);
        if (eff_deq > count) begin
            eff_deq = count;
        end
        if (eff_deq > CW'(OUT_WIDTH)) begin
            eff_deq = CW'(OUT_WIDTH);
        end
    end

    // Present the oldest entries in program order; empty lanes show a bubble.
    always_comb begin
        for (int i = 0; i < int'(OUT_WIDTH); i++) begin
            out_valid[i] = CW'(i) < count;
            out_inst[i]  = out_valid[i] ? storage[ptr_add(head, i)] : INST_Q_ZERO;
        end
    end

    // Pointer, occupancy and storage update; flush keeps storage, reset clears it.
    always_ff @(posedge clock) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int d = 0; d < int'(DEPTH); d++) begin
                storage[d] <= INST_Q_ZERO;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq_fire) begin
                for (int i = 0; i < int'(IN_WIDTH); i++) begin
                    if (in_valid[i]) begin
                        storage[ptr_add(tail, 32'(lane_off[i]))] <= in_inst[i];
                    end
                end
                tail <= ptr_add(tail, 32'(lane_total));
            end
            head  <= ptr_add(head, 32'(eff_deq));
            count <= count + (enq_fire ? CW'(lane_total) : CW'(0)) - eff_deq;
        end
    end

endmodule
